// File: rtl/mem_access_sequencer.sv
// Sequences one pipeline load/store into big-endian single-byte accesses on a
// byte-wide RAM, stalling the pipeline until a registered completion pulse.
module mem_access_sequencer #(
    parameter int MEM_BYTES = 40,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        memread,
    input  logic [1:0]        memwrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic              stall,
    output logic              ready,
    output logic              err,
    output logic [31:0]       read_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state_q;
    logic              is_load_q;
    logic [1:0]        size_q;
    logic [1:0]        k_q;
    logic [31:0]       wdata_q;
    logic [23:0]       shift_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       read_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    // Size code shared by both opcode fields: 01 word, 10 byte, 11 half.
    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'b01:   return 3'd4;
            2'b11:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] idx);
        return d[8*idx +: 8];
    endfunction

    // Byte index to store in the beat after beat k: (N-1) - (k+1).
    function automatic logic [1:0] next_store_idx(input logic [1:0] sz, input logic [1:0] k);
        logic [2:0] idx;
        idx = nbytes(sz) - 3'd2 - {1'b0, k};
        return idx[1:0];
    endfunction

    logic [1:0]      req_size;
    logic [2:0]      req_n;
    logic [1:0]      req_first_idx;
    logic            req_bad_op;
    logic            req_misaligned;
    logic [ADDR_W:0] req_end;
    logic            req_out_of_range;
    logic            req_invalid;
    logic            req_is_store;
    logic            xfer_last;
    logic [31:0]     assembled;
    logic [31:0]     load_result;

    always_comb begin
        req_size         = memread | memwrite;
        req_n            = nbytes(req_size);
        req_first_idx    = 2'(req_n - 3'd1);
        req_bad_op       = (memread != 2'b00) == (memwrite != 2'b00);
        req_misaligned   = ((req_size == 2'b01) && (address[1:0] != 2'b00)) ||
                           ((req_size == 2'b11) && address[0]);
        // One extra bit so an address near the top cannot wrap past the limit.
        req_end          = {1'b0, address} + {{(ADDR_W-2){1'b0}}, req_n};
        req_out_of_range = req_end > MEM_LIMIT;
        req_invalid      = req_bad_op || req_misaligned || req_out_of_range;
        req_is_store     = memwrite != 2'b00;
    end

    always_comb begin
        xfer_last = {1'b0, k_q} == (nbytes(size_q) - 3'd1);
        // The final byte is still on mem_rdata when the result is formed.
        assembled = {shift_q, mem_rdata};
        case (size_q)
            2'b01:   load_result = assembled;
            2'b11:   load_result = {{16{assembled[15]}}, assembled[15:0]};
            default: load_result = {{24{assembled[7]}}, assembled[7:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            size_q      <= 2'b00;
            k_q         <= 2'd0;
            wdata_q     <= 32'd0;
            shift_q     <= 24'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_addr_q  <= '0;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= 8'd0;
                    if (req) begin
                        is_load_q <= !req_is_store;
                        size_q    <= req_size;
                        wdata_q   <= writedata;
                        k_q       <= 2'd0;
                        if (req_invalid) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_XFER;
                            mem_addr_q  <= address;
                            mem_we_q    <= req_is_store;
                            mem_wdata_q <= req_is_store ? byte_sel(writedata, req_first_idx) : 8'd0;
                        end
                    end
                end
                S_XFER: begin
                    if (is_load_q) begin
                        shift_q <= {shift_q[15:0], mem_rdata};
                    end
                    if (xfer_last) begin
                        state_q     <= S_DONE;
                        ready_q     <= 1'b1;
                        mem_addr_q  <= '0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 8'd0;
                        if (is_load_q) begin
                            read_data_q <= load_result;
                        end
                    end else begin
                        k_q         <= k_q + 2'd1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= is_load_q ? 8'd0 : byte_sel(wdata_q, next_store_idx(size_q, k_q));
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = req & ~ready_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign read_data = read_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte RAM model, directed scenarios and a
// randomized run checked against a byte-array reference of load/store semantics.
module tb_mem_access_sequencer;
    localparam int MB = 40;

    logic        clk;
    logic        reset;
    logic        req;
    logic [1:0]  memread;
    logic [1:0]  memwrite;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        stall;
    logic        ready;
    logic        err;
    logic [31:0] read_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_state;

    mem_access_sequencer #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .memread(memread), .memwrite(memwrite),
        .address(address), .writedata(writedata), .stall(stall), .ready(ready),
        .err(err), .read_data(read_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ram     [0:MB-1];
    logic [7:0]  ref_mem [0:MB-1];
    logic [31:0] ref_rd;
    logic [31:0] exp_q[$];
    int          errors;
    int          checks;

    assign mem_rdata = (mem_addr < 32'(MB)) ? ram[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'(MB)) ram[mem_addr] <= mem_wdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_access(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                                input logic [31:0] wd, output bit bad, output int lat, output int nwe);
        int n;
        logic [31:0] v;
        logic [1:0] sz;
        sz = rd | wr;
        n = (sz == 2'b01) ? 4 : (sz == 2'b11) ? 2 : 1;
        bad = ((rd != 0) == (wr != 0)) || (n == 4 && a % 4 != 0) || (n == 2 && a % 2 != 0) ||
              (longint'(a) + longint'(n) > longint'(MB));
        nwe = 0;
        if (bad) begin
            lat = 1;
        end else begin
            lat = n + 1;
            if (wr != 0) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * (n - 1 - i)));
                nwe = n;
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a + i]);
                if (n == 2 && v[15]) v = v | 32'hFFFF0000;
                if (n == 1 && v[7])  v = v | 32'hFFFFFF00;
                ref_rd = v;
            end
        end
        exp_q.push_back(ref_rd);
    endtask

    // ---------------- driver ----------------
    task automatic run_req(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output bit e,
                           output logic [31:0] rdat, output int nwe, output logic [31:0] we_addr,
                           output bit stall_bad);
        @(negedge clk);
        req = 1'b1; memread = rd; memwrite = wr; address = a; writedata = wd;
        #1;
        stall_bad = (stall !== 1'b1);
        lat = 0; nwe = 0; e = 1'b0; rdat = 32'hx; we_addr = 32'hFFFF_FFFF;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (mem_we === 1'b1) begin nwe++; we_addr = mem_addr; end
            if (ready === 1'b1) begin
                e = err; rdat = read_data;
                if (stall !== 1'b0) stall_bad = 1'b1;
                break;
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
        end
        @(negedge clk);
        req = 1'b0; memread = 2'b00; memwrite = 2'b00; address = 32'd0; writedata = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'd0)  begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 8'd0)  begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    // Runs a directed step list; each step fully compared against the model.
    task automatic test_directed(input string nm, input int steps, input int sel);
        logic [1:0] rd, wr; logic [31:0] a, wd, rdat, wa, exp; int lat, elat, nwe, enwe; bit e, bad, sb;
        for (int i = 0; i < steps; i++) begin
            rd = 0; wr = 0; a = 0; wd = 0;
            case (sel * 8 + i)
                0:  begin wr = 2'b01; a = 8; wd = 32'h12345678; end
                1:  begin rd = 2'b01; a = 8; end
                8:  begin wr = 2'b10; a = 3; wd = 32'h000000F0; end
                9:  begin rd = 2'b10; a = 3; end
                10: begin wr = 2'b10; a = 3; wd = 32'h00000070; end
                11: begin rd = 2'b10; a = 3; end
                16: begin wr = 2'b11; a = 6; wd = 32'h0000BEEF; end
                17: begin rd = 2'b01; a = 4; end
                18: begin rd = 2'b11; a = 6; end
                24: begin rd = 2'b01; a = 5; end
                25: begin wr = 2'b11; a = 3; wd = 32'h1111_2222; end
                26: begin rd = 2'b01; a = 40; end
                27: begin rd = 2'b01; a = 32'hFFFFFFFC; end
                28: begin rd = 2'b01; wr = 2'b01; a = 16; wd = 32'h55667788; end
                29: begin a = 16; end
                30: begin wr = 2'b10; a = 39; wd = 32'h0000005A; end
                31: begin rd = 2'b01; a = 36; end
                default: ;
            endcase
            run_req(rd, wr, a, wd, lat, e, rdat, nwe, wa, sb);
            model_access(rd, wr, a, wd, bad, elat, enwe);
            exp = exp_q.pop_front();
            checks++; if (lat !== elat) begin errors++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", nm, i, lat, elat); end
            checks++; if (e !== bad)    begin errors++; $display("FAIL %s[%0d] err got=%b exp=%b", nm, i, e, bad); end
            checks++; if (rdat !== exp) begin errors++; $display("FAIL %s[%0d] read_data got=%h exp=%h", nm, i, rdat, exp); end
            checks++; if (nwe !== enwe) begin errors++; $display("FAIL %s[%0d] we_cycles got=%0d exp=%0d", nm, i, nwe, enwe); end
            checks++; if (sb)           begin errors++; $display("FAIL %s[%0d] stall profile got=bad exp=high-until-ready", nm, i); end
            if (sel == 1 && wr != 0) begin
                checks++; if (wa !== 32'd3) begin errors++; $display("FAIL %s[%0d] we_addr got=%0d exp=3", nm, i, wa); end
            end
            if (sel == 0 && i == 1) begin
                checks++; if (rdat !== 32'h12345678) begin errors++; $display("FAIL lw8 value got=%h exp=12345678", rdat); end
            end
            if (sel == 1 && i == 1) begin
                checks++; if (rdat !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb3 neg got=%h exp=fffffff0", rdat); end
            end
            if (sel == 1 && i == 3) begin
                checks++; if (rdat !== 32'h00000070) begin errors++; $display("FAIL lb3 pos got=%h exp=00000070", rdat); end
            end
            if (sel == 2 && i == 2) begin
                checks++; if (rdat !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh6 got=%h exp=ffffbeef", rdat); end
            end
        end
    endtask

    task automatic test_word();
        test_directed("word", 2, 0);
        checks++; if ({ram[8], ram[9], ram[10], ram[11]} !== 32'h12345678)
            begin errors++; $display("FAIL word_bytes got=%h exp=12345678", {ram[8], ram[9], ram[10], ram[11]}); end
    endtask

    task automatic test_byte();
        test_directed("byte", 4, 1);
        checks++; if (ram[3] !== 8'h70) begin errors++; $display("FAIL byte_ram3 got=%h exp=70", ram[3]); end
    endtask

    task automatic test_half();
        logic [7:0] b4, b5;
        b4 = ref_mem[4]; b5 = ref_mem[5];
        test_directed("half", 3, 2);
        checks++; if ({ram[6], ram[7]} !== 16'hBEEF) begin errors++; $display("FAIL half_bytes got=%h exp=beef", {ram[6], ram[7]}); end
        checks++; if ({ram[4], ram[5]} !== {b4, b5}) begin errors++; $display("FAIL half_neighbours got=%h exp=%h", {ram[4], ram[5]}, {b4, b5}); end
    endtask

    task automatic test_errors();
        test_directed("errors", 8, 3);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rdat, wa, exp; int lat, elat, nwe, enwe; bit e, bad, sb; bit saw_ready;
        run_req(2'b00, 2'b01, 32'd12, 32'h01020304, lat, e, rdat, nwe, wa, sb);
        model_access(2'b00, 2'b01, 32'd12, 32'h01020304, bad, elat, enwe);
        void'(exp_q.pop_front());
        @(negedge clk);
        req = 1'b1; memwrite = 2'b01; address = 32'd12; writedata = 32'hAABBCCDD;
        repeat (3) @(posedge clk);
        #1; reset = 1'b1; req = 1'b0; memwrite = 2'b00;
        #1;
        checks++; if ({ready, err, mem_we} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b exp=000", {ready, err, mem_we}); end
        checks++; if ({read_data, mem_addr, mem_wdata} !== 72'd0)
            begin errors++; $display("FAIL abort_buses got=%h/%h/%h exp=0", read_data, mem_addr, mem_wdata); end
        saw_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (ready === 1'b1) saw_ready = 1'b1; end
        @(negedge clk); reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (ready === 1'b1) saw_ready = 1'b1; end
        checks++; if (saw_ready) begin errors++; $display("FAIL abort_no_ready got=pulse exp=none"); end
        ref_mem[12] = 8'hAA; ref_mem[13] = 8'hBB; ref_rd = 32'd0;
        checks++; if ({ram[12], ram[13], ram[14], ram[15]} !== 32'hAABB0304)
            begin errors++; $display("FAIL abort_bytes got=%h exp=aabb0304", {ram[12], ram[13], ram[14], ram[15]}); end
        run_req(2'b01, 2'b00, 32'd12, 32'd0, lat, e, rdat, nwe, wa, sb);
        model_access(2'b01, 2'b00, 32'd12, 32'd0, bad, elat, enwe);
        exp = exp_q.pop_front();
        checks++; if (rdat !== exp || rdat !== 32'hAABB0304) begin errors++; $display("FAIL abort_reload got=%h exp=%h", rdat, exp); end
        checks++; if (lat !== 5 || e !== 1'b0) begin errors++; $display("FAIL abort_reload_timing got=lat%0d/err%b exp=lat5/err0", lat, e); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rd, wr, sz; logic [31:0] a, wd, rdat, wa, exp; int lat, elat, nwe, enwe, n; bit e, bad, sb;
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(1, 3));
            rd = 0; wr = 0;
            if ($urandom_range(0, 1) == 0) rd = sz; else wr = sz;
            if ($urandom_range(0, 9) == 0) begin rd = 2'($urandom_range(0, 3)); wr = 2'($urandom_range(0, 3)); end
            n = (sz == 2'b01) ? 4 : (sz == 2'b11) ? 2 : 1;
            a = 32'($urandom_range(0, 43));
            if ($urandom_range(0, 3) != 0) a = a - (a % 32'(n));
            if ($urandom_range(0, 14) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            wd = $urandom;
            run_req(rd, wr, a, wd, lat, e, rdat, nwe, wa, sb);
            model_access(rd, wr, a, wd, bad, elat, enwe);
            exp = exp_q.pop_front();
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand[%0d] latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (e !== bad)    begin errors++; $display("FAIL rand[%0d] err got=%b exp=%b", i, e, bad); end
            checks++; if (rdat !== exp) begin errors++; $display("FAIL rand[%0d] read_data got=%h exp=%h", i, rdat, exp); end
            checks++; if (nwe !== enwe) begin errors++; $display("FAIL rand[%0d] we_cycles got=%0d exp=%0d", i, nwe, enwe); end
            checks++; if (sb)           begin errors++; $display("FAIL rand[%0d] stall profile got=bad exp=high-until-ready", i); end
        end
        for (int j = 0; j < MB; j++) begin
            checks++; if (ram[j] !== ref_mem[j]) begin errors++; $display("FAIL mem[%0d] got=%h exp=%h", j, ram[j], ref_mem[j]); end
        end
    endtask

    initial begin
        errors = 0; checks = 0; ref_rd = 32'd0;
        reset = 1'b1; req = 1'b0; memread = 2'b00; memwrite = 2'b00; address = 32'd0; writedata = 32'd0;
        for (int j = 0; j < MB; j++) begin
            ref_mem[j] = 8'($urandom);
            ram[j] <= ref_mem[j];
        end
        #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
